// File: rtl/dm_ctrl_if.sv
// Request/response bus between a requester and the dm_ctrl data-memory controller.
// The requester uses the master modport; the controller uses the slave modport.
interface dm_ctrl_if #(
    parameter int ADDR_W = 9
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_ctrl.sv
// Single-port data-memory controller: byte/half/word loads and stores with optional wait states.
// Define DM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err.
module dm_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_ctrl_if.slave    bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic              accept;
    logic              commit;
    logic              mem_we;
    logic [ADDR_W-3:0] widx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [31:0]       wr_data;
    logic [3:0]        be;
    logic [31:0]       acc_rdata;
    logic              acc_err;
    logic              misaligned;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // The access path works on the _d operands so a zero-wait access can commit on the accept edge.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = bus.req_we;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
        end
    end

    assign widx    = addr_d[ADDR_W-1:2];
    assign lane    = addr_d[1:0];
    assign rd_word = mem[widx];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        be         = 4'b1111;
        wr_data    = wdata_d;
        acc_rdata  = rd_word;
        acc_err    = 1'b0;
        misaligned = 1'b0;
        sel_byte   = rd_word[8*lane +: 8];
        sel_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (size_d)
            2'b00: begin
                be        = 4'b0001 << lane;
                wr_data   = {4{wdata_d[7:0]}};
                acc_rdata = {{24{sel_byte[7] & ~uns_d}}, sel_byte};
            end
            2'b01: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{wdata_d[15:0]}};
                acc_rdata  = {{16{sel_half[15] & ~uns_d}}, sel_half};
                misaligned = lane[0];
            end
            default: begin
                misaligned = (lane != 2'b00);
            end
        endcase
`ifdef DM_MISALIGN_TRAP_EN
        if (misaligned) begin
            be        = 4'b0000;
            acc_rdata = 32'h0;
            acc_err   = 1'b1;
        end
`endif
        if (we_d) begin
            acc_rdata = 32'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            rdata_d = acc_rdata;
            err_d   = acc_err;
        end
    end

    // Gating with rst_n keeps an edge sampled during reset from writing the array.
    assign mem_we = commit && we_d && rst_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: a zero-wait and a three-wait instance share the request stimulus.
// Expectations for misaligned accesses follow DM_MISALIGN_TRAP_EN.
module tb_dm_ctrl;
    localparam int ADDR_W = 9;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       exp_rd;
        logic              exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_extra_n;
    logic req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0] req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0] req_wdata;
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    dm_ctrl_if #(.ADDR_W(ADDR_W)) if0 ();
    dm_ctrl_if #(.ADDR_W(ADDR_W)) if3 ();

    assign if0.req_valid = req_valid;    assign if3.req_valid = req_valid;
    assign if0.req_we = req_we;          assign if3.req_we = req_we;
    assign if0.req_size = req_size;      assign if3.req_size = req_size;
    assign if0.req_unsigned = req_unsigned; assign if3.req_unsigned = req_unsigned;
    assign if0.req_addr = req_addr;      assign if3.req_addr = req_addr;
    assign if0.req_wdata = req_wdata;    assign if3.req_wdata = req_wdata;
    assign if0.rsp_ready = rsp_ready;    assign if3.rsp_ready = rsp_ready;

    dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n & rst3_extra_n), .bus(if3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    // One transaction on both instances; latency counts edges from the accept edge to visible rsp_valid.
    task automatic txn(input vec_t v, output logic [31:0] rd0, output logic [31:0] rd3,
                       output logic e0, output logic e3, output int lat0, output int lat3);
        bit g0 = 1'b0;
        bit g3 = 1'b0;
        rd0 = '0; rd3 = '0; e0 = 1'b0; e3 = 1'b0; lat0 = 0; lat3 = 0;
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20 && !(g0 && g3); n++) begin
            if (!g0 && if0.rsp_valid) begin g0 = 1'b1; lat0 = n; rd0 = if0.rsp_rdata; e0 = if0.rsp_err; end
            if (!g3 && if3.rsp_valid) begin g3 = 1'b1; lat3 = n; rd3 = if3.rsp_rdata; e3 = if3.rsp_err; end
            if (!(g0 && g3)) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd0, rd3;
        logic e0, e3;
        int lat0, lat3, n;
        vec_t v;

        //             we    size  uns   addr     wdata          exp_rd                     exp_err
        vq.push_back('{1'b1, SZ_W, 1'b0, 9'h010, 32'hDEADBEEF, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_W, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF,               1'b0});
        vq.push_back('{1'b1, SZ_W, 1'b0, 9'h010, 32'h0,        32'h0,                      1'b0});
        vq.push_back('{1'b1, SZ_B, 1'b0, 9'h013, 32'h12345680, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b0, 9'h013, 32'h0,        32'hFFFFFF80,               1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b1, 9'h013, 32'h0,        32'h00000080,               1'b0});
        vq.push_back('{1'b0, SZ_W, 1'b0, 9'h010, 32'h0,        32'h80000000,               1'b0});
        vq.push_back('{1'b1, SZ_H, 1'b0, 9'h012, 32'hAAAA1234, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_H, 1'b0, 9'h012, 32'h0,        32'h00001234,               1'b0});
        vq.push_back('{1'b1, SZ_H, 1'b0, 9'h010, 32'h00008001, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_H, 1'b0, 9'h010, 32'h0,        32'hFFFF8001,               1'b0});
        vq.push_back('{1'b0, SZ_H, 1'b1, 9'h010, 32'h0,        32'h00008001,               1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b0, 9'h011, 32'h0,        32'hFFFFFF80,               1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b0, 9'h010, 32'h0,        32'h00000001,               1'b0});
        vq.push_back('{1'b0, SZ_W, 1'b1, 9'h010, 32'h0,        32'h12348001,               1'b0});
        vq.push_back('{1'b1, SZ_R, 1'b0, 9'h040, 32'hCAFEF00D, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_R, 1'b0, 9'h040, 32'h0,        32'hCAFEF00D,               1'b0});
        vq.push_back('{1'b1, SZ_W, 1'b0, 9'h1FC, 32'hA5A5A5A5, 32'h0,                      1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b1, 9'h1FF, 32'h0,        32'h000000A5,               1'b0});
        vq.push_back('{1'b0, SZ_B, 1'b0, 9'h1FE, 32'h0,        32'hFFFFFFA5,               1'b0});
        vq.push_back('{1'b1, SZ_W, 1'b0, 9'h030, 32'h0BADF00D, 32'h0,                      1'b0});
        vq.push_back('{1'b1, SZ_W, 1'b0, 9'h020, 32'h0,        32'h0,                      1'b0});
        vq.push_back('{1'b1, SZ_H, 1'b0, 9'h021, 32'h0000BEEF, 32'h0,                      TRAP});
        vq.push_back('{1'b0, SZ_W, 1'b0, 9'h020, 32'h0,        TRAP ? 32'h0 : 32'h0000BEEF, 1'b0});
        vq.push_back('{1'b0, SZ_W, 1'b0, 9'h022, 32'h0,        TRAP ? 32'h0 : 32'h0000BEEF, TRAP});
        vq.push_back('{1'b0, SZ_H, 1'b1, 9'h023, 32'h0,        32'h0,                      TRAP});
        vq.push_back('{1'b0, SZ_B, 1'b1, 9'h021, 32'h0,        TRAP ? 32'h0 : 32'h000000BE, 1'b0});

        rst_n = 1'b0; rst3_extra_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset req_ready0", 32'(if0.req_ready), 32'd1);
        check("reset req_ready3", 32'(if3.req_ready), 32'd1);
        check("reset rsp_valid3", 32'(if3.rsp_valid), 32'd0);
        check("reset rsp_rdata3", if3.rsp_rdata, 32'h0);
        check("reset rsp_err3",   32'(if3.rsp_err), 32'd0);

        foreach (vq[i]) begin
            txn(vq[i], rd0, rd3, e0, e3, lat0, lat3);
            check($sformatf("v%0d rdata0", i), rd0, vq[i].exp_rd);
            check($sformatf("v%0d rdata3", i), rd3, vq[i].exp_rd);
            check($sformatf("v%0d err0", i), 32'(e0), 32'(vq[i].exp_err));
            check($sformatf("v%0d err3", i), 32'(e3), 32'(vq[i].exp_err));
            check($sformatf("v%0d latency0", i), 32'(lat0), 32'd1);
            check($sformatf("v%0d latency3", i), 32'(lat3), 32'd4);
        end

        // Load with response back-pressure while a store request is held on the bus.
        @(negedge clk);
        v = '{1'b0, SZ_W, 1'b0, 9'h010, 32'h0, 32'h0, 1'b0};
        drive(v);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        v = '{1'b1, SZ_W, 1'b0, 9'h010, 32'hFFFFFFFF, 32'h0, 1'b0};
        drive(v);
        n = 1;
        while (!if3.rsp_valid && n < 20) begin
            check("wait req_ready3", 32'(if3.req_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("stall latency3", 32'(n), 32'd4);
        for (int k = 0; k < 5; k++) begin
            check("stall rsp_valid3", 32'(if3.rsp_valid), 32'd1);
            check("stall rsp_rdata3", if3.rsp_rdata, 32'h12348001);
            check("stall req_ready3", 32'(if3.req_ready), 32'd0);
            check("stall rsp_rdata0", if0.rsp_rdata, 32'h12348001);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release rsp_valid3", 32'(if3.rsp_valid), 32'd0);
        check("release req_ready3", 32'(if3.req_ready), 32'd1);
        txn('{1'b0, SZ_W, 1'b0, 9'h010, 32'h0, 32'h0, 1'b0}, rd0, rd3, e0, e3, lat0, lat3);
        check("ignored store rdata3", rd3, 32'h12348001);
        check("ignored store rdata0", rd0, 32'h12348001);

        // Reset of the waiting instance two edges after a store is accepted.
        @(negedge clk);
        v = '{1'b1, SZ_W, 1'b0, 9'h030, 32'h55555555, 32'h0, 1'b0};
        drive(v);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3_extra_n = 1'b0;
        #1;
        check("abort rsp_valid3", 32'(if3.rsp_valid), 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst3_extra_n = 1'b1;
        check("abort req_ready3", 32'(if3.req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("abort no rsp3", 32'(if3.rsp_valid), 32'd0);
        end
        txn('{1'b0, SZ_W, 1'b0, 9'h030, 32'h0, 32'h0, 1'b0}, rd0, rd3, e0, e3, lat0, lat3);
        check("abort word3", rd3, 32'h0BADF00D);
        check("abort latency3", 32'(lat3), 32'd4);
        check("committed word0", rd0, 32'h55555555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width; depth is 2**(ADDR_W-2) 32-bit words (default 128).
REQ-002 Parameter WAIT_CYCLES, default 0, extra wait states inserted before each access commits.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 req_unsigned  input  1  loads zero-extend when 1, sign-extend when 0.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-015 rsp_err  output  1  access rejected (see Configuration).

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept on req_valid & req_ready edge: capture we, size, unsigned, addr, wdata; go to WAIT if WAIT_CYCLES > 0, else RESP.
REQ-018 WAIT: counter loaded with WAIT_CYCLES-1 on accept, decrements each cycle; at 0 go to RESP.
REQ-019 Memory access commits on the edge entering RESP; rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid & rsp_ready edge, then IDLE; next accept no earlier than following edge.
REQ-021 Lanes little-endian: byte lane = addr[1:0], half lane = addr[1] (bytes 1:0 or 3:2); word index = addr[ADDR_W-1:2].
REQ-022 Stores write only the addressed lane(s); other bytes of the word unchanged.
REQ-023 Loads extract addressed lane, extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-024 req_valid while not IDLE is ignored and has no effect; requester holds it until req_ready.
REQ-025 Store followed by load to same word returns updated data (no stale read).

Reset
REQ-026 rst_n low: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
REQ-027 Memory array is not reset; contents undefined until written.
REQ-028 Reset asserted in WAIT aborts the transaction with no memory write; in RESP the pending response is discarded.

Configuration
REQ-029 Macro DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word/reserved with addr[1:0]!=00 is misaligned -> no memory write, rsp_rdata 0, rsp_err 1, same latency.
REQ-030 DM_MISALIGN_TRAP_EN undefined: misalignment ignored (half uses addr[1], word ignores addr[1:0]); rsp_err tied 0.

Verification
REQ-031 WAIT_CYCLES=0: store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid 1 cycle after each accept.
REQ-032 Store byte 0x80 @0x13 over word 0x00000000, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80000000.
REQ-033 WAIT_CYCLES=3: accept load -> rsp_valid rises exactly 4 cycles later; req_ready 0 throughout; extra req_valid ignored.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable; req_ready stays 0 until handshake.
REQ-035 With DM_MISALIGN_TRAP_EN: store half 0xBEEF @0x21 -> rsp_err 1, word @0x20 unchanged; without macro -> half written to bytes 1:0, rsp_err 0.
REQ-036 WAIT_CYCLES=3: rst_n pulsed low 2 cycles after accepting store -> no response, target word unchanged, req_ready 1 after release.
